// File: rtl/nw_pkg.sv
// -----------------------------------------------------------------------------
// nw_pkg
// Shared definitions for the Needleman-Wunsch alignment controller:
//   - 3-bit state encodings (also exported on state_dbg)
//   - default sequence length
//   - scoring constants used by the datapath
//   - control-strobe bundle and a state -> strobe decoder
// -----------------------------------------------------------------------------
package nw_pkg;

    localparam int DEFAULT_N      = 5;

    localparam int SCORE_GAP      = -2;
    localparam int SCORE_MATCH    = 1;
    localparam int SCORE_MISMATCH = -1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_INS   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_TRACE = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } nw_state_e;

    typedef struct packed {
        logic en_init;
        logic en_read;
        logic en_ins;
        logic we;
        logic en_trace_b;
        logic change_index;
        logic busy;
        logic done;
        logic error;
    } nw_ctrl_t;

    // Moore decode: every control output is a pure function of the state.
    function automatic nw_ctrl_t decode_state(input nw_state_e st);
        nw_ctrl_t c;
        c = '0;
        case (st)
            ST_IDLE:  c = '0;
            ST_INIT:  begin c.en_init      = 1'b1; c.we = 1'b1; c.busy = 1'b1; end
            ST_READ:  begin c.en_read      = 1'b1;              c.busy = 1'b1; end
            ST_INS:   begin c.en_ins       = 1'b1; c.we = 1'b1; c.busy = 1'b1; end
            ST_NEXT:  begin c.change_index = 1'b1;              c.busy = 1'b1; end
            ST_TRACE: begin c.en_trace_b   = 1'b1;              c.busy = 1'b1; end
            ST_DONE:  begin c.done         = 1'b1;              c.busy = 1'b1; end
            ST_ERR:   begin c.error        = 1'b1;              c.busy = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nw_phase_timer.sv
// -----------------------------------------------------------------------------
// nw_phase_timer
// Loadable down-counter shared by the controller for two mutually exclusive
// jobs: timing the insertion phase and acting as the wait-state watchdog.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   W-bit reload value
//   dec      in   decrement by one, holds at zero
//   tc       out  terminal count: current count is zero
// -----------------------------------------------------------------------------
module nw_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/nw_controller.sv
// -----------------------------------------------------------------------------
// nw_controller
// Sequencing FSM for a Needleman-Wunsch scoring datapath: initialises row/col 0,
// then for each of the N*N cells reads, inserts (held INS_CYCLES cycles) and
// advances the index, then runs traceback. Wait states are watchdog-guarded;
// a timeout parks the FSM in ERR until reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    level, sampled only in IDLE
//   end_init, calculated,
//   end_filling, end_c       datapath handshakes
//   en_init, en_read, en_ins,
//   we, en_traceB,
//   change_index             registered datapath control strobes
//   cell_idx                 current cell, row-major, 0-based, saturating
//   busy, done, error        status (done is a 1-cycle pulse, error sticky)
//   state_dbg                current state encoding
// -----------------------------------------------------------------------------
module nw_controller
    import nw_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int INS_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      end_init,
    input  logic                      calculated,
    input  logic                      end_filling,
    input  logic                      end_c,
    output logic                      en_init,
    output logic                      en_read,
    output logic                      en_ins,
    output logic                      we,
    output logic                      en_traceB,
    output logic                      change_index,
    output logic [$clog2(N*N)-1:0]    cell_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [2:0]                state_dbg
);

    localparam int                IDX_W    = $clog2(N*N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N*N - 1);
    localparam int                TW       = 8;
    localparam logic [TW-1:0]     INS_LOAD = TW'(INS_CYCLES - 1);
    localparam logic [TW-1:0]     WD_LOAD  = TW'(TIMEOUT - 1);

    nw_state_e        state_q, state_d;
    logic [IDX_W-1:0] cell_idx_q, cell_idx_d;
    logic             fill_seen_q, fill_seen_d;
    nw_ctrl_t         ctrl_q, ctrl_d;

    logic             timer_load;
    logic [TW-1:0]    timer_load_val;
    logic             timer_dec;
    logic             timer_tc;

    // One counter serves both INS duration and the watchdog: the two are
    // never needed in the same state, and it is reloaded on every state change.
    nw_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .tc       (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        cell_idx_d  = cell_idx_q;
        fill_seen_d = fill_seen_q;
        timer_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_INIT;
                    cell_idx_d = '0;
                end
            end
            // In the wait states the exit condition is tested before the
            // timeout so a same-cycle handshake always wins.
            ST_INIT: begin
                if (end_init)      state_d   = ST_READ;
                else if (timer_tc) state_d   = ST_ERR;
                else               timer_dec = 1'b1;
            end
            ST_READ: begin
                if (calculated)    state_d   = ST_INS;
                else if (timer_tc) state_d   = ST_ERR;
                else               timer_dec = 1'b1;
            end
            ST_INS: begin
                // Remember end_filling seen on any INS cycle so an early
                // report still ends filling after this insertion completes.
                if (end_filling) fill_seen_d = 1'b1;
                if (timer_tc) begin
                    if (end_filling || fill_seen_q || (cell_idx_q == LAST_IDX))
                        state_d = ST_TRACE;
                    else
                        state_d = ST_NEXT;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_NEXT: begin
                if (cell_idx_q != LAST_IDX) cell_idx_d = cell_idx_q + 1'b1;
                state_d = ST_READ;
            end
            ST_TRACE: begin
                if (end_c)         state_d   = ST_DONE;
                else if (timer_tc) state_d   = ST_ERR;
                else               timer_dec = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_INS) && (state_q != ST_INS)) fill_seen_d = 1'b0;

        timer_load     = (state_d != state_q);
        timer_load_val = (state_d == ST_INS) ? INS_LOAD : WD_LOAD;

        // Outputs are registered from the next state so they line up with
        // state_q without any input-to-output combinational path.
        ctrl_d = decode_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cell_idx_q  <= '0;
            fill_seen_q <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            cell_idx_q  <= cell_idx_d;
            fill_seen_q <= fill_seen_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign en_init      = ctrl_q.en_init;
    assign en_read      = ctrl_q.en_read;
    assign en_ins       = ctrl_q.en_ins;
    assign we           = ctrl_q.we;
    assign en_traceB    = ctrl_q.en_trace_b;
    assign change_index = ctrl_q.change_index;
    assign busy         = ctrl_q.busy;
    assign done         = ctrl_q.done;
    assign error        = ctrl_q.error;
    assign cell_idx     = cell_idx_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_nw_controller.sv
// -----------------------------------------------------------------------------
// tb_nw_controller
// Directed bench: instance A (N=2, INS_CYCLES=4, TIMEOUT=10) covers the full
// run, watchdog, reset-mid-INS and start-held cases; instance B (defaults,
// N=5) covers early end_filling. Each instance is held in reset while the
// other is exercised. A negedge monitor checks strobe exclusivity and we.
// -----------------------------------------------------------------------------
module tb_nw_controller;
    import nw_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic start, end_init, calculated, end_filling, end_c;

    logic a_en_init, a_en_read, a_en_ins, a_we, a_en_traceB, a_change_index;
    logic a_busy, a_done, a_error;
    logic [1:0] a_cell;
    logic [2:0] a_state;

    logic b_en_init, b_en_read, b_en_ins, b_we, b_en_traceB, b_change_index;
    logic b_busy, b_done, b_error;
    logic [4:0] b_cell;
    logic [2:0] b_state;

    int checks = 0;
    int errors = 0;
    int ci_a = 0, ci_b = 0, done_a = 0, done_b = 0;
    int ci_base, done_base, done_tick, found, restarted;

    nw_controller #(.N(2), .INS_CYCLES(4), .TIMEOUT(10)) u_a (
        .clk(clk), .rst(rst_a), .start(start), .end_init(end_init),
        .calculated(calculated), .end_filling(end_filling), .end_c(end_c),
        .en_init(a_en_init), .en_read(a_en_read), .en_ins(a_en_ins), .we(a_we),
        .en_traceB(a_en_traceB), .change_index(a_change_index), .cell_idx(a_cell),
        .busy(a_busy), .done(a_done), .error(a_error), .state_dbg(a_state)
    );

    nw_controller #(.N(5)) u_b (
        .clk(clk), .rst(rst_b), .start(start), .end_init(end_init),
        .calculated(calculated), .end_filling(end_filling), .end_c(end_c),
        .en_init(b_en_init), .en_read(b_en_read), .en_ins(b_en_ins), .we(b_we),
        .en_traceB(b_en_traceB), .change_index(b_change_index), .cell_idx(b_cell),
        .busy(b_busy), .done(b_done), .error(b_error), .state_dbg(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: strobes mutually exclusive, we exactly in INIT/INS.
    always @(negedge clk) begin
        chk("onehot_a", 32'($countones({a_en_init, a_en_read, a_en_ins, a_en_traceB, a_change_index}) <= 1), 1);
        chk("onehot_b", 32'($countones({b_en_init, b_en_read, b_en_ins, b_en_traceB, b_change_index}) <= 1), 1);
        chk("we_a", a_we, 32'(a_state == ST_INIT || a_state == ST_INS));
        chk("we_b", b_we, 32'(b_state == ST_INIT || b_state == ST_INS));
        if (a_change_index) ci_a++;
        if (b_change_index) ci_b++;
        if (a_done) done_a++;
        if (b_done) done_b++;
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start = 1'b0; end_init = 1'b0; calculated = 1'b0; end_filling = 1'b0; end_c = 1'b0;
        tick(); tick();
        $display("step: reset");
        chk("rst_state_a", a_state, ST_IDLE);
        chk("rst_busy_a", a_busy, 0);
        chk("rst_cell_a", a_cell, 0);
        chk("rst_error_a", a_error, 0);
        chk("rst_done_a", a_done, 0);
        chk("rst_state_b", b_state, ST_IDLE);
        rst_a = 1'b0;
        tick();
        chk("idle_hold", a_state, ST_IDLE);

        // ---------------- full run, N=2 ----------------
        $display("step: full run N=2");
        start = 1'b1; tick(); start = 1'b0;
        chk("init_state", a_state, ST_INIT);
        chk("init_en", a_en_init, 1);
        chk("init_we", a_we, 1);
        chk("init_busy", a_busy, 1);
        tick(); tick();
        chk("init_wait", a_state, ST_INIT);
        end_init = 1'b1; tick(); end_init = 1'b0;
        ci_base = ci_a; done_base = done_a;
        for (int c = 0; c < 4; c++) begin
            chk("read_state", a_state, ST_READ);
            chk("read_cell", a_cell, c);
            chk("read_en", a_en_read, 1);
            tick();
            chk("read_wait", a_state, ST_READ);
            calculated = 1'b1; tick(); calculated = 1'b0;
            chk("ins_state", a_state, ST_INS);
            chk("ins_we", a_we, 1);
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("ins_hold", a_state, ST_INS);
            end
            tick();
            if (c < 3) begin
                chk("next_state", a_state, ST_NEXT);
                chk("next_ci", a_change_index, 1);
                chk("next_cell", a_cell, c);
                tick();
            end else begin
                chk("trace_state", a_state, ST_TRACE);
                chk("trace_cell", a_cell, 3);
                chk("trace_en", a_en_traceB, 1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("trace_wait", a_state, ST_TRACE);
        end
        end_c = 1'b1; tick(); end_c = 1'b0;
        chk("done_state", a_state, ST_DONE);
        chk("done_pulse", a_done, 1);
        chk("done_busy", a_busy, 1);
        tick();
        chk("post_idle", a_state, ST_IDLE);
        chk("post_done", a_done, 0);
        chk("post_busy", a_busy, 0);
        chk("post_error", a_error, 0);
        chk("ci_pulses", ci_a - ci_base, 3);
        chk("done_pulses", done_a - done_base, 1);

        // ---------------- READ watchdog ----------------
        $display("step: read timeout");
        start = 1'b1; tick(); start = 1'b0;
        end_init = 1'b1; tick(); end_init = 1'b0;
        chk("wd_read_entry", a_state, ST_READ);
        for (int k = 0; k < 8; k++) tick();
        tick();
        chk("wd_read_last", a_state, ST_READ);
        tick();
        chk("wd_err_state", a_state, ST_ERR);
        chk("wd_err_flag", a_error, 1);
        chk("wd_err_busy", a_busy, 1);
        chk("wd_err_we", a_we, 0);
        chk("wd_err_read", a_en_read, 0);
        start = 1'b1; tick(); tick(); start = 1'b0;
        chk("err_sticky", a_state, ST_ERR);
        chk("err_sticky_flag", a_error, 1);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        chk("err_rst_state", a_state, ST_IDLE);
        chk("err_rst_flag", a_error, 0);
        chk("err_rst_busy", a_busy, 0);

        // ---------------- INIT watchdog ----------------
        $display("step: init timeout");
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("wd_init_last", a_state, ST_INIT);
        tick();
        chk("wd_init_err", a_state, ST_ERR);
        rst_a = 1'b1; tick(); rst_a = 1'b0;

        // ---------------- exit beats timeout, then reset mid-INS ----------------
        $display("step: exit at timeout and reset in INS");
        start = 1'b1; tick(); start = 1'b0;
        end_init = 1'b1; tick(); end_init = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("race_read", a_state, ST_READ);
        calculated = 1'b1; tick(); calculated = 1'b0;
        chk("race_exit_wins", a_state, ST_INS);
        for (int k = 0; k < 4; k++) tick();
        chk("race_next", a_state, ST_NEXT);
        tick();
        calculated = 1'b1; tick(); calculated = 1'b0;
        tick();
        chk("mid_ins_state", a_state, ST_INS);
        chk("mid_ins_cell", a_cell, 1);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        chk("mid_rst_ins", a_en_ins, 0);
        chk("mid_rst_we", a_we, 0);
        chk("mid_rst_state", a_state, ST_IDLE);
        chk("mid_rst_cell", a_cell, 0);

        // ---------------- start held through the run ----------------
        $display("step: start held high");
        end_init = 1'b1; calculated = 1'b1; end_c = 1'b1; start = 1'b1;
        done_tick = 0; restarted = 0;
        for (int t = 1; t <= 60 && done_tick == 0; t++) begin
            tick();
            if (t > 1 && a_state == ST_INIT) restarted = 1;
            if (a_done) done_tick = t;
        end
        chk("held_done_tick", done_tick, 26);
        chk("held_no_restart", restarted, 0);
        tick();
        chk("held_idle", a_state, ST_IDLE);
        chk("held_idle_busy", a_busy, 0);
        tick();
        chk("held_rerun", a_state, ST_INIT);
        chk("held_rerun_cell", a_cell, 0);
        start = 1'b0; end_init = 1'b0; calculated = 1'b0; end_c = 1'b0;
        rst_a = 1'b1;

        // ---------------- early end_filling, N=5 ----------------
        $display("step: end_filling at cell 7 N=5");
        rst_b = 1'b0; tick();
        end_init = 1'b1; calculated = 1'b1; start = 1'b1; tick(); start = 1'b0;
        ci_base = ci_b; done_base = done_b; found = 0;
        for (int t = 0; t < 80 && found == 0; t++) begin
            // end_filling pulsed in READ at cell 3 must be ignored
            end_filling = (b_state == ST_READ && b_cell == 3);
            tick();
            if (b_state == ST_INS && b_cell == 7) found = 1;
        end
        end_filling = 1'b0;
        chk("ef_reach_cell7", found, 1);
        chk("ef_ci_before", ci_b - ci_base, 7);
        end_filling = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ef_ins_hold", b_state, ST_INS);
        end
        tick();
        end_filling = 1'b0;
        chk("ef_trace", b_state, ST_TRACE);
        chk("ef_trace_cell", b_cell, 7);
        chk("ef_trace_ci", b_change_index, 0);
        tick(); tick();
        chk("ef_ci_after", ci_b - ci_base, 7);
        end_c = 1'b1; tick(); end_c = 1'b0;
        chk("ef_done", b_done, 1);
        tick();
        chk("ef_idle", b_state, ST_IDLE);
        chk("ef_done_pulses", done_b - done_base, 1);
        chk("ef_error", b_error, 0);
        end_init = 1'b0; calculated = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
